// File: rtl/interrupt_arbiter.sv
// Multiplexes N edge-triggered interrupt sources onto one core interrupt pin.
// Define INTERRUPT_ARBITER_RR_EN for round-robin arbitration; the default is fixed priority.
module interrupt_arbiter #(
  parameter int                   N_SOURCES = 4,
  parameter int                   ID_W      = 2,
  parameter logic [N_SOURCES-1:0] MASK_INIT = '1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_SOURCES-1:0] i_irq,
  input  logic                 i_mask_wr,
  input  logic [N_SOURCES-1:0] i_mask,
  input  logic                 i_ack,
  output logic                 o_interrupt,
  output logic [ID_W-1:0]      o_irq_id,
  output logic [N_SOURCES-1:0] o_pending,
  output logic [N_SOURCES-1:0] o_mask,
  output logic                 o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT_ACK
  } state_t;

  state_t               r_state;
  logic [N_SOURCES-1:0] r_prev;
  logic [N_SOURCES-1:0] r_pending;
  logic [N_SOURCES-1:0] r_mask;
  logic [ID_W-1:0]      r_irq_id;
  logic                 r_interrupt;
  logic                 r_busy;
`ifdef INTERRUPT_ARBITER_RR_EN
  logic [ID_W-1:0]      r_last_grant;
`endif

  logic [N_SOURCES-1:0] w_rise;
  logic [N_SOURCES-1:0] w_req;
  logic [N_SOURCES-1:0] w_clr;
  logic                 w_any;
  logic [ID_W-1:0]      w_winner;

  assign w_rise = i_irq & ~r_prev;
  assign w_req  = r_pending & r_mask;
  assign w_any  = |w_req;

  // One-hot clear of the acknowledged source; only meaningful in WAIT_ACK.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_SOURCES; i++) begin
      w_clr[i] = (r_state == S_WAIT_ACK) && i_ack && (r_irq_id == ID_W'(i));
    end
  end

`ifdef INTERRUPT_ARBITER_RR_EN
  logic w_found;
  int   w_idx;

  // Search begins just past the previous winner and wraps modulo N_SOURCES.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int off = 1; off <= N_SOURCES; off++) begin
      w_idx = (int'(r_last_grant) + off) % N_SOURCES;
      if (!w_found && w_req[w_idx]) begin
        w_winner = ID_W'(w_idx);
        w_found  = 1'b1;
      end
    end
  end
`else
  // Scanning downward lets the lowest requesting index overwrite the others.
  always_comb begin
    w_winner = '0;
    for (int i = N_SOURCES - 1; i >= 0; i--) begin
      if (w_req[i]) w_winner = ID_W'(i);
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    if (i_rst) begin
      // Loading the live request vector means a line held high through reset yields no edge.
      r_prev      <= i_irq;
      r_pending   <= '0;
      r_mask      <= MASK_INIT;
      r_irq_id    <= '0;
      r_interrupt <= 1'b0;
      r_busy      <= 1'b0;
      r_state     <= S_IDLE;
`ifdef INTERRUPT_ARBITER_RR_EN
      r_last_grant <= ID_W'(N_SOURCES - 1);
`endif
    end else begin
      r_prev      <= i_irq;
      // Set wins over the ack clear so a fresh edge on the acked source re-fires.
      r_pending   <= (r_pending & ~w_clr) | w_rise;
      r_interrupt <= 1'b0;
      if (i_mask_wr) r_mask <= i_mask;

      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_irq_id    <= w_winner;
            r_interrupt <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_FIRE;
`ifdef INTERRUPT_ARBITER_RR_EN
            r_last_grant <= w_winner;
`endif
          end
        end
        S_FIRE: begin
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (i_ack) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_interrupt = r_interrupt;
  assign o_irq_id    = r_irq_id;
  assign o_pending   = r_pending;
  assign o_mask      = r_mask;
  assign o_busy      = r_busy;

endmodule
